// File: rtl/mmio_master.sv
// MMIO bus initiator: one CPU load/store at a time, lane handling and load extension.
// Optional access timeout is compiled in with `define MMIO_MASTER_TIMEOUT_EN.
module mmio_master #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        sys_clk,
    input  logic        rst_n,
    input  logic        cpu_req_valid,
    output logic        cpu_req_ready,
    input  logic        cpu_req_we,
    input  logic [1:0]  cpu_req_size,
    input  logic        cpu_req_unsigned,
    input  logic [31:0] cpu_req_addr,
    input  logic [31:0] cpu_req_wdata,
    output logic        cpu_resp_valid,
    output logic [31:0] cpu_resp_rdata,
    output logic        cpu_resp_err,
    output logic        mmio_read,
    output logic        mmio_write,
    output logic [31:0] mmio_addr,
    output logic [31:0] mmio_write_data,
    input  logic        mmio_read_done,
    input  logic        mmio_write_done,
    input  logic [31:0] mmio_read_data
);

    typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;

    state_t      state, state_next;
    logic [31:0] addr_q;
    logic [1:0]  size_q;
    logic        unsigned_q;
    logic [31:0] wdata_q;
    logic [31:0] resp_rdata_q, resp_rdata_next;
    logic        resp_err_q, resp_err_next;
    logic        req_err;
    logic        timeout_hit;
    logic [7:0]  byte_lane;
    logic [15:0] half_lane;
    logic [31:0] load_data;
    logic [31:0] lane_wdata;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        req_err = 1'b0;
        case (cpu_req_size)
            2'b00:   req_err = 1'b0;
            2'b01:   req_err = cpu_req_addr[0];
            2'b10:   req_err = |cpu_req_addr[1:0];
            default: req_err = 1'b1;
        endcase
    end

    // Store data is replicated across every lane the access could hit.
    always_comb begin
        lane_wdata = cpu_req_wdata;
        case (cpu_req_size)
            2'b00:   lane_wdata = {4{cpu_req_wdata[7:0]}};
            2'b01:   lane_wdata = {2{cpu_req_wdata[15:0]}};
            default: lane_wdata = cpu_req_wdata;
        endcase
    end

    always_comb begin
        byte_lane = mmio_read_data[7:0];
        case (addr_q[1:0])
            2'b00:   byte_lane = mmio_read_data[7:0];
            2'b01:   byte_lane = mmio_read_data[15:8];
            2'b10:   byte_lane = mmio_read_data[23:16];
            default: byte_lane = mmio_read_data[31:24];
        endcase
        half_lane = addr_q[1] ? mmio_read_data[31:16] : mmio_read_data[15:0];
        load_data = mmio_read_data;
        case (size_q)
            2'b00:   load_data = unsigned_q ? {24'd0, byte_lane}
                                            : {{24{byte_lane[7]}}, byte_lane};
            2'b01:   load_data = unsigned_q ? {16'd0, half_lane}
                                            : {{16{half_lane[15]}}, half_lane};
            default: load_data = mmio_read_data;
        endcase
    end

`ifdef MMIO_MASTER_TIMEOUT_EN
    localparam logic [15:0] TIMEOUT_LIMIT = 16'(TIMEOUT_CYCLES);
    logic [15:0] wait_cnt;

    // The cycle holding count LIMIT-1 is the last one the request stays up.
    assign timeout_hit = ((wait_cnt + 16'd1) == TIMEOUT_LIMIT);

    always_ff @(posedge sys_clk) begin
        if (!rst_n || state == IDLE) begin
            wait_cnt <= 16'd0;
        end else if (state == READ || state == WRITE) begin
            wait_cnt <= wait_cnt + 16'd1;
        end
    end
`else
    assign timeout_hit = 1'b0;
`endif

    always_comb begin
        state_next      = state;
        resp_rdata_next = 32'd0;
        resp_err_next   = 1'b0;
        case (state)
            IDLE: begin
                if (cpu_req_valid) begin
                    if (req_err) begin
                        state_next    = RESP;
                        resp_err_next = 1'b1;
                    end else begin
                        state_next = cpu_req_we ? WRITE : READ;
                    end
                end
            end
            READ: begin
                if (mmio_read_done) begin
                    state_next      = RESP;
                    resp_rdata_next = load_data;
                end else if (timeout_hit) begin
                    state_next    = RESP;
                    resp_err_next = 1'b1;
                end
            end
            WRITE: begin
                if (mmio_write_done) begin
                    state_next = RESP;
                end else if (timeout_hit) begin
                    state_next    = RESP;
                    resp_err_next = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge sys_clk) begin
        if (!rst_n) begin
            state        <= IDLE;
            addr_q       <= 32'd0;
            size_q       <= 2'b00;
            unsigned_q   <= 1'b0;
            wdata_q      <= 32'd0;
            resp_rdata_q <= 32'd0;
            resp_err_q   <= 1'b0;
        end else begin
            state        <= state_next;
            resp_rdata_q <= resp_rdata_next;
            resp_err_q   <= resp_err_next;
            if (state == IDLE && cpu_req_valid) begin
                addr_q     <= cpu_req_addr;
                size_q     <= cpu_req_size;
                unsigned_q <= cpu_req_unsigned;
                wdata_q    <= lane_wdata;
            end
        end
    end

    assign cpu_req_ready   = (state == IDLE) && rst_n;
    assign cpu_resp_valid  = (state == RESP);
    assign cpu_resp_rdata  = resp_rdata_q;
    assign cpu_resp_err    = resp_err_q;
    assign mmio_read       = (state == READ);
    assign mmio_write      = (state == WRITE);
    assign mmio_addr       = addr_q;
    assign mmio_write_data = wdata_q;

endmodule

// File: tb/tb_mmio_master.sv
// Directed bench for mmio_master: loads, stores, error path, reset abort, optional timeout.
`timescale 1ns/1ps
module tb_mmio_master;

    logic        sys_clk = 1'b0;
    logic        rst_n;
    logic        cpu_req_valid;
    logic        cpu_req_ready;
    logic        cpu_req_we;
    logic [1:0]  cpu_req_size;
    logic        cpu_req_unsigned;
    logic [31:0] cpu_req_addr;
    logic [31:0] cpu_req_wdata;
    logic        cpu_resp_valid;
    logic [31:0] cpu_resp_rdata;
    logic        cpu_resp_err;
    logic        mmio_read;
    logic        mmio_write;
    logic [31:0] mmio_addr;
    logic [31:0] mmio_write_data;
    logic        mmio_read_done;
    logic        mmio_write_done;
    logic [31:0] mmio_read_data;

    int vectors = 0;
    int miscompares = 0;

    always #5 sys_clk = ~sys_clk;

    mmio_master #(.TIMEOUT_CYCLES(8)) dut (
        .sys_clk         (sys_clk),
        .rst_n           (rst_n),
        .cpu_req_valid   (cpu_req_valid),
        .cpu_req_ready   (cpu_req_ready),
        .cpu_req_we      (cpu_req_we),
        .cpu_req_size    (cpu_req_size),
        .cpu_req_unsigned(cpu_req_unsigned),
        .cpu_req_addr    (cpu_req_addr),
        .cpu_req_wdata   (cpu_req_wdata),
        .cpu_resp_valid  (cpu_resp_valid),
        .cpu_resp_rdata  (cpu_resp_rdata),
        .cpu_resp_err    (cpu_resp_err),
        .mmio_read       (mmio_read),
        .mmio_write      (mmio_write),
        .mmio_addr       (mmio_addr),
        .mmio_write_data (mmio_write_data),
        .mmio_read_done  (mmio_read_done),
        .mmio_write_done (mmio_write_done),
        .mmio_read_data  (mmio_read_data)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Inputs change and outputs are sampled 1ns after the rising edge.
    task automatic step();
        @(posedge sys_clk);
        #1;
    endtask

    // Issues one request; the responder raises done in the lat-th busy cycle (lat=0: never).
    task automatic run_txn(input logic we, input logic [1:0] size, input logic uns,
                           input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [31:0] rdata, input int lat,
                           output int busy, output int resp_cyc,
                           output logic [31:0] resp_data, output logic resp_err,
                           output logic [31:0] bus_addr, output logic [31:0] bus_wdata,
                           output logic both_hi);
        cpu_req_valid    = 1'b1;
        cpu_req_we       = we;
        cpu_req_size     = size;
        cpu_req_unsigned = uns;
        cpu_req_addr     = addr;
        cpu_req_wdata    = wdata;
        step();
        cpu_req_valid = 1'b0;
        busy = 0;
        resp_cyc = 0;
        resp_data = 32'hDEAD_DEAD;
        resp_err = 1'bx;
        bus_addr = 32'd0;
        bus_wdata = 32'd0;
        both_hi = 1'b0;
        for (int c = 1; c <= 40; c++) begin
            if (cpu_resp_valid) begin
                resp_cyc  = c;
                resp_data = cpu_resp_rdata;
                resp_err  = cpu_resp_err;
                break;
            end
            if (mmio_read && mmio_write) both_hi = 1'b1;
            if (mmio_read || mmio_write) begin
                busy++;
                if (busy == 1) begin
                    bus_addr  = mmio_addr;
                    bus_wdata = mmio_write_data;
                end
                if (busy == lat) begin
                    mmio_read_done  = !we;
                    mmio_write_done = we;
                    mmio_read_data  = rdata;
                end
            end
            step();
        end
        mmio_read_done  = 1'b0;
        mmio_write_done = 1'b0;
        mmio_read_data  = 32'h0;
        step();
    endtask

    int          busy, resp_cyc;
    logic [31:0] rdat, baddr, bwdata;
    logic        rerr, both;

    initial begin
        rst_n = 1'b0;
        cpu_req_valid = 1'b0;
        cpu_req_we = 1'b0;
        cpu_req_size = 2'b00;
        cpu_req_unsigned = 1'b0;
        cpu_req_addr = 32'h0;
        cpu_req_wdata = 32'h0;
        mmio_read_done = 1'b0;
        mmio_write_done = 1'b0;
        mmio_read_data = 32'h0;
        step();
        step();
        rst_n = 1'b1;
        #1;
        check("reset_ready", {31'd0, cpu_req_ready}, 32'd1);
        check("reset_bus", {29'd0, mmio_read, mmio_write, cpu_resp_valid}, 32'd0);
        check("reset_resp", {cpu_resp_rdata[30:0], cpu_resp_err}, 32'd0);

        // Word load, done in third busy cycle.
        run_txn(1'b0, 2'b10, 1'b0, 32'h1000_0004, 32'h0, 32'h8000_00FF, 3,
                busy, resp_cyc, rdat, rerr, baddr, bwdata, both);
        check("wload_busy", busy, 3);
        check("wload_lat", resp_cyc, 4);
        check("wload_data", rdat, 32'h8000_00FF);
        check("wload_err", {31'd0, rerr}, 32'd0);
        check("wload_addr", baddr, 32'h1000_0004);
        check("wload_pulse", {30'd0, cpu_resp_valid, cpu_req_ready}, 32'd1);

        // Signed then unsigned byte load from lane 3, done with the request.
        run_txn(1'b0, 2'b00, 1'b0, 32'h1000_0003, 32'h0, 32'h8500_0000, 1,
                busy, resp_cyc, rdat, rerr, baddr, bwdata, both);
        check("sbyte_data", rdat, 32'hFFFF_FF85);
        check("sbyte_lat", resp_cyc, 2);
        run_txn(1'b0, 2'b00, 1'b1, 32'h1000_0003, 32'h0, 32'h8500_0000, 2,
                busy, resp_cyc, rdat, rerr, baddr, bwdata, both);
        check("ubyte_data", rdat, 32'h0000_0085);

        // Signed halfword loads from both halves.
        run_txn(1'b0, 2'b01, 1'b0, 32'h1000_0002, 32'h0, 32'h8001_7FFF, 1,
                busy, resp_cyc, rdat, rerr, baddr, bwdata, both);
        check("shalf_hi", rdat, 32'hFFFF_8001);
        run_txn(1'b0, 2'b01, 1'b0, 32'h1000_0000, 32'h0, 32'h8001_7FFF, 1,
                busy, resp_cyc, rdat, rerr, baddr, bwdata, both);
        check("shalf_lo", rdat, 32'h0000_7FFF);
        run_txn(1'b0, 2'b00, 1'b1, 32'h1000_0001, 32'h0, 32'h0000_A500, 1,
                busy, resp_cyc, rdat, rerr, baddr, bwdata, both);
        check("ubyte_l1", rdat, 32'h0000_00A5);

        // Stores: lane replication, address, zero read data.
        run_txn(1'b1, 2'b01, 1'b0, 32'h1000_0002, 32'h1234_ABCD, 32'h0, 2,
                busy, resp_cyc, rdat, rerr, baddr, bwdata, both);
        check("hstore_wdata", bwdata, 32'hABCD_ABCD);
        check("hstore_addr", baddr, 32'h1000_0002);
        check("hstore_err", {31'd0, rerr}, 32'd0);
        check("hstore_rdata", rdat, 32'd0);
        check("hstore_busy", busy, 2);
        check("hstore_excl", {31'd0, both}, 32'd0);
        run_txn(1'b1, 2'b00, 1'b0, 32'h2000_0001, 32'hFFFF_FF5A, 32'h0, 1,
                busy, resp_cyc, rdat, rerr, baddr, bwdata, both);
        check("bstore_wdata", bwdata, 32'h5A5A_5A5A);
        run_txn(1'b1, 2'b10, 1'b0, 32'h2000_0008, 32'hCAFE_F00D, 32'h0, 1,
                busy, resp_cyc, rdat, rerr, baddr, bwdata, both);
        check("wstore_wdata", bwdata, 32'hCAFE_F00D);

        // Error paths: no bus activity, response one cycle after accept.
        run_txn(1'b0, 2'b10, 1'b0, 32'h1000_0001, 32'h0, 32'h0, 1,
                busy, resp_cyc, rdat, rerr, baddr, bwdata, both);
        check("mis_word_busy", busy, 0);
        check("mis_word_lat", resp_cyc, 1);
        check("mis_word_err", {31'd0, rerr}, 32'd1);
        check("mis_word_rdata", rdat, 32'd0);
        run_txn(1'b1, 2'b01, 1'b0, 32'h1000_0003, 32'h0, 32'h0, 1,
                busy, resp_cyc, rdat, rerr, baddr, bwdata, both);
        check("mis_half_err", {31'd0, rerr}, 32'd1);
        check("mis_half_busy", busy, 0);
        run_txn(1'b0, 2'b11, 1'b0, 32'h1000_0000, 32'h0, 32'h0, 1,
                busy, resp_cyc, rdat, rerr, baddr, bwdata, both);
        check("rsvd_size_err", {31'd0, rerr}, 32'd1);

        // Reset while a read is outstanding aborts it silently.
        cpu_req_valid = 1'b1;
        cpu_req_we = 1'b0;
        cpu_req_size = 2'b10;
        cpu_req_addr = 32'h1000_0010;
        step();
        cpu_req_valid = 1'b0;
        check("abort_inread", {31'd0, mmio_read}, 32'd1);
        step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        #1;
        check("abort_state", {29'd0, mmio_read, cpu_resp_valid, cpu_req_ready}, 32'd1);
        mmio_read_done = 1'b1;
        mmio_read_data = 32'h1234_5678;
        step();
        mmio_read_done = 1'b0;
        check("abort_late_done", {29'd0, mmio_read, cpu_resp_valid, cpu_req_ready}, 32'd1);
        step();
        check("abort_quiet", {30'd0, cpu_resp_valid, cpu_resp_err}, 32'd0);

`ifdef MMIO_MASTER_TIMEOUT_EN
        run_txn(1'b0, 2'b10, 1'b0, 32'h1000_0020, 32'h0, 32'h0, 0,
                busy, resp_cyc, rdat, rerr, baddr, bwdata, both);
        check("tmo_busy", busy, 8);
        check("tmo_err", {31'd0, rerr}, 32'd1);
        check("tmo_rdata", rdat, 32'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
